button_event_gen: RTL and testbench
===================================

// Module: button_event_gen
// PURPOSE
//  Consumes the clean level from the button debouncer (o_state) and turns it into one-cycle event pulses:
//  press, release, long-press and auto-repeat while held.
//  Sits between the debouncer and board-level consumers (single-step/run control, mode select).
//  All outputs are registered; one clock domain.
// PARAMETERS
//  CNT_W          24               width of the hold counter; LONG_CYCLES and REPEAT_CYCLES must fit in it
//  LONG_CYCLES    24'd5_000_000    cycles from press until o_long fires; legal range >= 2
//  REPEAT_CYCLES  24'd1_000_000    cycles between o_repeat pulses after o_long; legal range >= 1
//  REPEAT_EN      1                1 = auto-repeat after long press, 0 = o_repeat is held at 0
// PORTS
//  i_clk     in   1  clock
//  i_rst     in   1  reset, asynchronous, active-low
//  i_state   in   1  debounced button level, 1 = pressed; already synchronous to i_clk
//  o_press   out  1  1-cycle pulse on press
//  o_release out  1  1-cycle pulse on release
//  o_long    out  1  1-cycle pulse once per press, when the press lasts LONG_CYCLES
//  o_repeat  out  1  1-cycle pulse every REPEAT_CYCLES while in HOLD
//  o_held    out  1  level, 1 while state != IDLE
// BEHAVIOUR
//  Reset (i_rst=0, async):
//   - state=IDLE, cnt=0.
//   - All outputs are 0 immediately, with no clock needed.
//   - No release pulse is generated for a press aborted by reset.
//  FSM, evaluated at each posedge. Pulse outputs default to 0 each cycle.
//   - IDLE:    i_state=1 -> PRESSED, cnt<=0, o_press<=1.
//   - PRESSED: i_state=0 -> IDLE, o_release<=1.
//              else if cnt==LONG_CYCLES-1 -> HOLD, cnt<=0, o_long<=1.
//              else cnt<=cnt+1.
//   - HOLD:    i_state=0 -> IDLE, o_release<=1.
//              else if cnt==REPEAT_CYCLES-1 -> cnt<=0, o_repeat<=REPEAT_EN.
//              else cnt<=cnt+1.
//  Latency and timing:
//   - Input edge sampled at edge N -> pulse visible in the cycle after edge N.
//   - o_long fires LONG_CYCLES cycles after o_press.
//   - The first o_repeat fires REPEAT_CYCLES cycles after o_long, then every REPEAT_CYCLES.
//  Priority:
//   - Release beats long and repeat in the same cycle; at most one pulse output is high in any cycle.
//  Counter:
//   - Unsigned, CNT_W bits; compared with == only, so it never wraps.
//   - With REPEAT_EN=0, cnt still cycles in HOLD (or may be frozen); this is not observable.
//  o_held:
//   - Registered; equals 1 exactly when the registered state is PRESSED or HOLD.
//  Reset release while i_state=1:
//   - The first edge sees IDLE with i_state=1, so o_press fires.
//   - This cannot happen with the debouncer, whose output resets to 0.
//  Illegal parameters (LONG_CYCLES<2, REPEAT_CYCLES<1, or values not fitting CNT_W) are out of scope;
//  simulation asserts on them.
// TESTING (CNT_W=4, LONG_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1 unless stated; edge 0 = first edge sampling i_state=1)
//  1. Hold i_rst=0 with i_state toggling -> all outputs stay 0.
//     Release reset with i_state=0 -> outputs still 0.
//  2. i_state=1 for edges 0..2, 0 from edge 3 -> o_press high after edge 0; o_held=1 after edges 0..2;
//     o_release high after edge 3; o_long, o_repeat never high.
//  3. i_state=1 for edges 0..7, 0 at edge 8 -> o_release after edge 8, no o_long (boundary miss).
//     Repeat with i_state=1 through edge 8 -> o_long after edge 8.
//  4. i_state=1 for edges 0..19, 0 at edge 20 -> o_press@0, o_long@8, o_repeat@12 and @16,
//     o_release@20 with no o_repeat@20 (release priority).
//     Checker: at most one pulse output high per cycle.
//  5. REPEAT_EN=0, i_state held 1 for 30 edges -> single o_long@8, o_repeat never high, o_held stays 1.
//  6. Drop i_rst to 0 mid-HOLD (edge 10 + half cycle) -> all outputs 0 asynchronously, no o_release.
//     Release reset with i_state=1 -> o_press one cycle after the first edge; with i_state=0 -> stays IDLE.

Source files
------------

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press, release, long-press and auto-repeat pulses.
// All outputs are registered; single clock domain with asynchronous active-low reset.
module button_event_gen #(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned LONG_CYCLES   = 5_000_000,
    parameter int unsigned REPEAT_CYCLES = 1_000_000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_state,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StHold
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
            o_held    <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_state) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                        o_press <= 1'b1;
                        o_held  <= 1'b1;
                    end
                end
                StPressed: begin
                    // Release has priority over the long-press boundary.
                    if (!i_state) begin
                        state_q   <= StIdle;
                        o_release <= 1'b1;
                        o_held    <= 1'b0;
                    end else if (cnt_q == LongLast) begin
                        state_q <= StHold;
                        cnt_q   <= '0;
                        o_long  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (!i_state) begin
                        state_q   <= StIdle;
                        o_release <= 1'b1;
                        o_held    <= 1'b0;
                    end else if (cnt_q == RepeatLast) begin
                        cnt_q    <= '0;
                        o_repeat <= REPEAT_EN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    o_held  <= 1'b0;
                end
            endcase
        end
    end

    // Parameter sanity; ignored by synthesis.
    always_ff @(posedge i_clk) begin
        assert (LONG_CYCLES >= 2);
        assert (REPEAT_CYCLES >= 1);
        assert ((LONG_CYCLES >> CNT_W) == 0);
        assert ((REPEAT_CYCLES >> CNT_W) == 0);
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Randomized scoreboard bench for button_event_gen, with a duration-based reference model.
module tb_button_event_gen;

    localparam int unsigned Long = 8;
    localparam int unsigned Rep  = 4;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_state;

    logic a_press, a_release, a_long, a_repeat, a_held;
    logic b_press, b_release, b_long, b_repeat, b_held;

    always #5 i_clk = ~i_clk;

    button_event_gen #(
        .CNT_W        (4),
        .LONG_CYCLES  (Long),
        .REPEAT_CYCLES(Rep),
        .REPEAT_EN    (1'b1)
    ) u_dut_a (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_state  (i_state),
        .o_press  (a_press),
        .o_release(a_release),
        .o_long   (a_long),
        .o_repeat (a_repeat),
        .o_held   (a_held)
    );

    button_event_gen #(
        .CNT_W        (4),
        .LONG_CYCLES  (Long),
        .REPEAT_CYCLES(Rep),
        .REPEAT_EN    (1'b0)
    ) u_dut_b (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_state  (i_state),
        .o_press  (b_press),
        .o_release(b_release),
        .o_long   (b_long),
        .o_repeat (b_repeat),
        .o_held   (b_held)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {press, release, long, repeat, held} for instance a (upper) and b (lower).
    logic [9:0] exp_q[$];

    // Model: whether the button is considered held, and edges elapsed since the press edge.
    bit m_held = 1'b0;
    int m_k    = 0;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (press,release,long,repeat,held) at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input bit r);
        logic [4:0] ea;
        logic [4:0] eb;
        ea = '0;
        eb = '0;
        if (!r) begin
            m_held = 1'b0;
            m_k    = 0;
        end else if (!m_held) begin
            if (s) begin
                m_held = 1'b1;
                m_k    = 0;
                ea[4]  = 1'b1;
                eb[4]  = 1'b1;
            end
        end else begin
            m_k++;
            if (!s) begin
                m_held = 1'b0;
                ea[3]  = 1'b1;
                eb[3]  = 1'b1;
            end else if (m_k == int'(Long)) begin
                ea[2] = 1'b1;
                eb[2] = 1'b1;
            end else if (m_k > int'(Long) && ((m_k - int'(Long)) % int'(Rep)) == 0) begin
                ea[1] = 1'b1;
            end
        end
        ea[0] = m_held;
        eb[0] = m_held;
        exp_q.push_back({ea, eb});
    endtask

    // Drive one cycle of inputs, then account for the edge that samples them.
    task automatic step(input bit s, input bit r);
        if (!r && i_rst === 1'b1 && exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
        i_state = s;
        i_rst   = r;
        @(posedge i_clk);
        model_edge(s, r);
        #1;
    endtask

    // Assert reset part-way through a cycle and check outputs clear without a clock.
    task automatic drop_reset_mid();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
        #2;
        i_rst = 1'b0;
        #1;
        chk("async_reset_a", {a_press, a_release, a_long, a_repeat, a_held}, 5'b0);
        chk("async_reset_b", {b_press, b_release, b_long, b_repeat, b_held}, 5'b0);
    endtask

    // Monitor: every cycle's registered outputs are checked against the scoreboard.
    always @(negedge i_clk) begin
        logic [9:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs_a", {a_press, a_release, a_long, a_repeat, a_held}, e[9:5]);
            chk("outputs_b", {b_press, b_release, b_long, b_repeat, b_held}, e[4:0]);
            chk("onehot_a", {4'b0, $onehot0({a_press, a_release, a_long, a_repeat})}, 5'd1);
            chk("onehot_b", {4'b0, $onehot0({b_press, b_release, b_long, b_repeat})}, 5'd1);
        end
    end

    initial begin
        i_rst   = 1'b1;
        i_state = 1'b0;
        #1;
        i_rst = 1'b0;
        #1;
        chk("reset_no_clock", {a_press, a_release, a_long, a_repeat, a_held}, 5'b0);

        // Reset held while the input toggles, then released with the button up.
        for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Short press.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Long-press boundary: one edge short, then exactly long enough.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Repeats, with release landing on a repeat boundary.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Held a long time.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1);

        // Reset mid-hold, release reset with the button still down, then with it up.
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1);
        drop_reset_mid();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Random bursts with occasional resets.
        for (int b = 0; b < 40; b++) begin
            int len;
            int gap;
            len = $urandom_range(0, 30);
            gap = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 63) == 0) step(1'b1, 1'b0);
                else step(1'b1, 1'b1);
            end
            for (int i = 0; i < gap; i++) step(1'b0, 1'b1);
        end

        repeat (3) @(negedge i_clk);
        #1;
        chk("scoreboard_drained", 5'(exp_q.size()), 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
